// File: rtl/pc_branch_unit.sv
// Per-thread next-PC generator: SEQ / NZP branch / CALL / RET with a private return-address stack.
// Optional macro PC_RELATIVE_BRANCH_EN selects PC-relative (sign-extended) branch/call targets.
module pc_branch_unit #(
  parameter int PC_WIDTH    = 8,
  parameter int IMM_WIDTH   = 8,
  parameter int STACK_DEPTH = 4,
  localparam int CNT_W      = $clog2(STACK_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 update_en,
  input  logic [1:0]           decoded_pc_mux,
  input  logic [2:0]           decoded_nzp,
  input  logic [IMM_WIDTH-1:0] decoded_immediate,
  input  logic                 decoded_nzp_write_enable,
  input  logic [2:0]           nzp_input_data,
  input  logic [PC_WIDTH-1:0]  current_pc,
  input  logic                 clear_flags,
  output logic [PC_WIDTH-1:0]  next_pc,
  output logic [2:0]           nzp,
  output logic [CNT_W-1:0]     stack_count,
  output logic                 stack_overflow,
  output logic                 stack_underflow
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] MUX_SEQ  = 2'b00;
  localparam logic [1:0] MUX_BR   = 2'b01;
  localparam logic [1:0] MUX_CALL = 2'b10;
  localparam logic [1:0] MUX_RET  = 2'b11;

  localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(STACK_DEPTH);
  localparam logic [CNT_W-1:0] COUNT_ONE  = CNT_W'(1);

  logic [PC_WIDTH-1:0] next_pc_q, next_pc_d;
  logic [2:0]          nzp_q, nzp_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic [PC_WIDTH-1:0] ras_q [STACK_DEPTH];

  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] imm_ext;
  logic [PC_WIDTH-1:0] target_pc;
  logic [IDX_W-1:0]    push_idx;
  logic [IDX_W-1:0]    top_idx;
  logic                push_en;
  logic                ovf_event;
  logic                unf_event;
  logic                ras_full;
  logic                ras_empty;
  logic                br_taken;

  assign seq_pc = current_pc + PC_WIDTH'(1);

  // Fit the immediate to PC_WIDTH: sign-extend for relative targets, zero-extend for absolute.
  generate
    if (IMM_WIDTH >= PC_WIDTH) begin : g_imm_trunc
      assign imm_ext = decoded_immediate[PC_WIDTH-1:0];
    end else begin : g_imm_ext
`ifdef PC_RELATIVE_BRANCH_EN
      assign imm_ext = {{(PC_WIDTH-IMM_WIDTH){decoded_immediate[IMM_WIDTH-1]}}, decoded_immediate};
`else
      assign imm_ext = {{(PC_WIDTH-IMM_WIDTH){1'b0}}, decoded_immediate};
`endif
    end
  endgenerate

`ifdef PC_RELATIVE_BRANCH_EN
  assign target_pc = current_pc + imm_ext;
`else
  assign target_pc = imm_ext;
`endif

  assign ras_full  = (count_q == COUNT_FULL);
  assign ras_empty = (count_q == '0);
  assign push_idx  = IDX_W'(count_q);
  assign top_idx   = IDX_W'(count_q - COUNT_ONE);
  // Branch condition deliberately uses the registered NZP, not this cycle's write data.
  assign br_taken  = |(nzp_q & decoded_nzp);

  always_comb begin
    next_pc_d = next_pc_q;
    nzp_d     = nzp_q;
    count_d   = count_q;
    push_en   = 1'b0;
    ovf_event = 1'b0;
    unf_event = 1'b0;

    if (decoded_nzp_write_enable) begin
      nzp_d = nzp_input_data;
    end

    if (update_en) begin
      case (decoded_pc_mux)
        MUX_SEQ: begin
          next_pc_d = seq_pc;
        end
        MUX_BR: begin
          next_pc_d = br_taken ? target_pc : seq_pc;
        end
        MUX_CALL: begin
          if (ras_full) begin
            next_pc_d = seq_pc;
            ovf_event = 1'b1;
          end else begin
            next_pc_d = target_pc;
            push_en   = 1'b1;
            count_d   = count_q + COUNT_ONE;
          end
        end
        MUX_RET: begin
          if (ras_empty) begin
            next_pc_d = seq_pc;
            unf_event = 1'b1;
          end else begin
            next_pc_d = ras_q[top_idx];
            count_d   = count_q - COUNT_ONE;
          end
        end
        default: begin
          next_pc_d = seq_pc;
        end
      endcase
    end

    // A new error in the same cycle as a clear leaves the flag set.
    ovf_d = (ovf_q & ~clear_flags) | ovf_event;
    unf_d = (unf_q & ~clear_flags) | unf_event;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      next_pc_q <= '0;
      nzp_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      next_pc_q <= next_pc_d;
      nzp_q     <= nzp_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  // Stack contents are don't-care after reset, so the storage carries no reset.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_q[push_idx] <= seq_pc;
    end
  end

  assign next_pc         = next_pc_q;
  assign nzp             = nzp_q;
  assign stack_count     = count_q;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboarded bench for pc_branch_unit: directed cases plus random traffic against a queue-based model.
module tb_pc_branch_unit;

  localparam int PCW   = 8;
  localparam int MODV  = 1 << PCW;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       update_en;
  logic [1:0] decoded_pc_mux;
  logic [2:0] decoded_nzp;
  logic [7:0] decoded_immediate;
  logic       decoded_nzp_write_enable;
  logic [2:0] nzp_input_data;
  logic [7:0] current_pc;
  logic       clear_flags;
  logic [7:0] next_pc;
  logic [2:0] nzp;
  logic [2:0] stack_count;
  logic       stack_overflow;
  logic       stack_underflow;

  pc_branch_unit #(.PC_WIDTH(8), .IMM_WIDTH(8), .STACK_DEPTH(DEPTH)) dut (
    .clk                      (clk),
    .reset                    (reset),
    .update_en                (update_en),
    .decoded_pc_mux           (decoded_pc_mux),
    .decoded_nzp              (decoded_nzp),
    .decoded_immediate        (decoded_immediate),
    .decoded_nzp_write_enable (decoded_nzp_write_enable),
    .nzp_input_data           (nzp_input_data),
    .current_pc               (current_pc),
    .clear_flags              (clear_flags),
    .next_pc                  (next_pc),
    .nzp                      (nzp),
    .stack_count              (stack_count),
    .stack_overflow           (stack_overflow),
    .stack_underflow          (stack_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic [2:0] nzp;
    logic [2:0] cnt;
    logic       ovf;
    logic       unf;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, kept as plain integers and a queue
  int m_pc;
  int m_nzp;
  int m_ras[$];
  bit m_ovf;
  bit m_unf;

  function automatic void chk(string nm, int got, int expv);
    n_checks++;
    if (got != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, expv);
    end
  endfunction

  function automatic void model_reset();
    m_pc  = 0;
    m_nzp = 0;
    m_ras.delete();
    m_ovf = 0;
    m_unf = 0;
  endfunction

  task automatic set_idle();
    update_en                = 1'b0;
    decoded_pc_mux           = 2'b00;
    decoded_nzp              = 3'b000;
    decoded_immediate        = 8'h00;
    decoded_nzp_write_enable = 1'b0;
    nzp_input_data           = 3'b000;
    current_pc               = 8'h00;
    clear_flags              = 1'b0;
  endtask

  // Drive one cycle of stimulus and queue the state the model expects after the next edge.
  task automatic cycle(input bit upd, input int op, input int mask, input int imm,
                       input int pc, input bit we, input int wdata, input bit clr,
                       input string nm);
    int   seq;
    int   tgt;
    int   simm;
    bit   ovf_ev;
    bit   unf_ev;
    exp_t e;
    @(negedge clk);
    update_en                = upd;
    decoded_pc_mux           = 2'(op);
    decoded_nzp              = 3'(mask);
    decoded_immediate        = 8'(imm);
    decoded_nzp_write_enable = we;
    nzp_input_data           = 3'(wdata);
    current_pc               = 8'(pc);
    clear_flags              = clr;

    seq    = (pc + 1) % MODV;
    simm   = (imm >= 128) ? imm - 256 : imm;
`ifdef PC_RELATIVE_BRANCH_EN
    tgt    = (pc + simm + MODV) % MODV;
`else
    tgt    = imm % MODV;
`endif
    ovf_ev = 0;
    unf_ev = 0;
    if (upd) begin
      case (op)
        0: m_pc = seq;
        1: m_pc = ((m_nzp & mask) != 0) ? tgt : seq;
        2: begin
          if (m_ras.size() < DEPTH) begin
            m_ras.push_back(seq);
            m_pc = tgt;
          end else begin
            m_pc   = seq;
            ovf_ev = 1;
          end
        end
        default: begin
          if (m_ras.size() > 0) begin
            m_pc = m_ras.pop_back();
          end else begin
            m_pc   = seq;
            unf_ev = 1;
          end
        end
      endcase
    end
    if (clr) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (ovf_ev) m_ovf = 1;
    if (unf_ev) m_unf = 1;
    if (we) m_nzp = wdata;

    e.pc  = 8'(m_pc);
    e.nzp = 3'(m_nzp);
    e.cnt = 3'(m_ras.size());
    e.ovf = m_ovf;
    e.unf = m_unf;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: every edge that follows a queued transaction is compared field by field.
  initial begin
    exp_t  e;
    string nm;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".next_pc"}, int'(next_pc), int'(e.pc));
        chk({nm, ".nzp"}, int'(nzp), int'(e.nzp));
        chk({nm, ".count"}, int'(stack_count), int'(e.cnt));
        chk({nm, ".ovf"}, int'(stack_overflow), int'(e.ovf));
        chk({nm, ".unf"}, int'(stack_underflow), int'(e.unf));
        $display("txn %-12s next_pc=%02h nzp=%03b cnt=%0d ovf=%0b unf=%0b", nm,
                 next_pc, nzp, stack_count, stack_overflow, stack_underflow);
      end
    end
  end

  task automatic check_all_zero(string nm);
    chk({nm, ".next_pc"}, int'(next_pc), 0);
    chk({nm, ".nzp"}, int'(nzp), 0);
    chk({nm, ".count"}, int'(stack_count), 0);
    chk({nm, ".ovf"}, int'(stack_overflow), 0);
    chk({nm, ".unf"}, int'(stack_underflow), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int pcs[4];
    pcs = '{10, 20, 30, 40};
    set_idle();
    reset = 1'b1;
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    cycle(1, 0, 0, 0, 8'hFF, 0, 0, 0, "seq_wrap");
    cycle(0, 0, 0, 0, 0, 1, 3'b010, 0, "nzp_wr");
    cycle(1, 1, 3'b010, 8'h40, 5, 0, 0, 0, "br_taken");
    cycle(1, 1, 3'b100, 8'h40, 5, 0, 0, 0, "br_not");
    cycle(1, 1, 3'b001, 8'h40, 9, 1, 3'b001, 0, "br_oldnzp");
    cycle(1, 1, 3'b001, 8'hFC, 8'h10, 0, 0, 0, "br_neg_imm");
    cycle(0, 2, 0, 8'h80, 3, 0, 0, 0, "hold");
    foreach (pcs[i]) cycle(1, 2, 0, 8'h80, pcs[i], 0, 0, 0, "call");
    cycle(1, 2, 0, 8'h80, 50, 0, 0, 0, "call_ovf");
    for (int i = 0; i < 4; i++) cycle(1, 3, 0, 0, 8'h80, 0, 0, 0, "ret");
    cycle(1, 3, 0, 0, 7, 0, 0, 0, "ret_unf");
    cycle(0, 0, 0, 0, 0, 0, 0, 1, "clear");
    cycle(1, 3, 0, 0, 12, 0, 0, 1, "clr_vs_unf");
    cycle(1, 2, 0, 8'h22, 60, 0, 0, 1, "call_a");
    cycle(1, 2, 0, 8'h33, 70, 0, 0, 0, "call_b");
    cycle(1, 3, 0, 0, 8'h33, 0, 0, 0, "ret_b");
    cycle(1, 2, 0, 8'h44, 90, 0, 0, 0, "call_after");
    cycle(1, 3, 0, 0, 8'h44, 0, 0, 0, "ret_c");
    cycle(1, 3, 0, 0, 8'h22, 0, 0, 0, "ret_a");

    for (int i = 0; i < 300; i++) begin
      cycle(($urandom_range(0, 9) < 8), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 7)), $urandom_range(0, 9) == 0, "rand");
    end

    cycle(0, 0, 0, 0, 0, 1, 3'b100, 0, "pre_rst_nzp");
    for (int i = 0; i < 5; i++) cycle(1, 2, 0, 8'h55, 100 + i, 0, 0, 0, "fill");
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    set_idle();
    reset = 1'b0;

    cycle(1, 3, 0, 0, 20, 0, 0, 0, "post_rst_ret");
    cycle(1, 0, 0, 0, 21, 0, 0, 0, "post_rst_seq");

    repeat (4) @(posedge clk);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
